// File: rtl/memory_pkg.sv
// Shared definitions for the line-granular memory model and the caches that talk to it.
package memory_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } memory_responder_state_t;

    // Number of byte-offset bits inside one cache line; caches reuse this for index/tag splits.
    function automatic int line_offset_bits(input int line_size);
        return $clog2(line_size / 8);
    endfunction

endpackage

// File: rtl/memory_interface.sv
// Line-wide request/response bus between a cache (master) and main memory (slave).
interface memory_interface #(
    parameter int ADDR_SIZE       = 32,
    parameter int CACHE_LINE_SIZE = 256
);

    logic [ADDR_SIZE-1:0]       addr;
    logic [CACHE_LINE_SIZE-1:0] wr_data;
    logic [CACHE_LINE_SIZE-1:0] rd_data;
    logic                       write;
    logic                       valid;
    logic                       ready;

    modport master (
        output addr, wr_data, write, valid,
        input  rd_data, ready
    );

    modport slave (
        input  addr, wr_data, write, valid,
        output rd_data, ready
    );

endinterface

// File: rtl/memory_line_array.sv
// Line storage with one synchronous write port and one registered read port.
module memory_line_array #(
    parameter int CACHE_LINE_SIZE = 256,
    parameter int SIZE_LINES      = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          we,
    input  logic [$clog2(SIZE_LINES)-1:0] windex,
    input  logic [CACHE_LINE_SIZE-1:0]    wdata,
    input  logic                          re,
    input  logic [$clog2(SIZE_LINES)-1:0] rindex,
    output logic [CACHE_LINE_SIZE-1:0]    rdata
);

    logic [CACHE_LINE_SIZE-1:0] lines [SIZE_LINES];

    // Contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            lines[windex] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= lines[rindex];
        end
    end

endmodule

// File: rtl/line_memory_responder.sv
// Slave-side main-memory model: accepts one line request, waits LATENCY cycles, pulses ready.
module line_memory_responder
    import memory_pkg::*;
#(
    parameter int ADDR_SIZE       = 32,
    parameter int CACHE_LINE_SIZE = 256,
    parameter int SIZE_LINES      = 1024,
    parameter int LATENCY         = 4
) (
    input  logic            clk_i,
    input  logic            reset_i,
    memory_interface.slave  memory_bus
);

    localparam int OFFSET_W = line_offset_bits(CACHE_LINE_SIZE);
    localparam int IDX_W    = $clog2(SIZE_LINES);
    localparam int CNT_W    = $clog2(LATENCY + 1);

    memory_responder_state_t state, next_state;

    logic [CNT_W-1:0]           count;
    logic [IDX_W-1:0]           req_index;
    logic                       req_write;
    logic [CACHE_LINE_SIZE-1:0] req_data;

    logic [IDX_W-1:0]           bus_index;
    logic                       accept;
    logic                       commit;
    logic                       ready;
    logic [IDX_W-1:0]           commit_index;
    logic                       commit_write;
    logic [CACHE_LINE_SIZE-1:0] commit_data;
    logic                       mem_we;
    logic                       mem_re;

    // Offset bits and bits above the index are dropped, so addresses alias modulo SIZE_LINES.
    if (ADDR_SIZE >= OFFSET_W + IDX_W) begin : g_index_slice
        assign bus_index = memory_bus.addr[OFFSET_W +: IDX_W];
    end else begin : g_index_shift
        assign bus_index = IDX_W'(memory_bus.addr >> OFFSET_W);
    end

    assign accept = (state == IDLE) && memory_bus.valid;

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (memory_bus.valid) begin
                    next_state = (LATENCY == 1) ? RESP : BUSY;
                    commit     = (LATENCY == 1);
                end
            end
            BUSY: begin
                if (count == CNT_W'(1)) begin
                    next_state = RESP;
                    commit     = 1'b1;
                end
            end
            RESP: begin
                ready      = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // With LATENCY=1 the commit edge is the accept edge, so the bus fields are used directly.
    assign commit_index = (state == IDLE) ? bus_index          : req_index;
    assign commit_write = (state == IDLE) ? memory_bus.write   : req_write;
    assign commit_data  = (state == IDLE) ? memory_bus.wr_data : req_data;

    assign mem_we = commit &&  commit_write && !reset_i;
    assign mem_re = commit && !commit_write && !reset_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state     <= IDLE;
            count     <= '0;
            req_index <= '0;
            req_write <= 1'b0;
            req_data  <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                req_index <= bus_index;
                req_write <= memory_bus.write;
                req_data  <= memory_bus.wr_data;
                count     <= CNT_W'(LATENCY - 1);
            end else if (state == BUSY) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    memory_line_array #(
        .CACHE_LINE_SIZE (CACHE_LINE_SIZE),
        .SIZE_LINES      (SIZE_LINES)
    ) u_lines (
        .clk    (clk_i),
        .rst    (reset_i),
        .we     (mem_we),
        .windex (commit_index),
        .wdata  (commit_data),
        .re     (mem_re),
        .rindex (commit_index),
        .rdata  (memory_bus.rd_data)
    );

    assign memory_bus.ready = ready;

endmodule

// File: tb/tb_line_memory_responder.sv
// Directed bench for line_memory_responder: a LATENCY=4 instance and a LATENCY=1 instance.
module tb_line_memory_responder;

    localparam int LAT4 = 4;
    localparam int LAT1 = 1;

    localparam logic [255:0] D1  = {4{64'h0123456789ABCDEF}};
    localparam logic [255:0] D2  = {{16{16'hFFFF}}, {16{16'h0000}}};
    localparam logic [255:0] D3  = {8{32'hDEADBEEF}};
    localparam logic [255:0] D4  = {32{8'h3C}};
    localparam logic [255:0] DA5 = {32{8'hA5}};

    typedef struct {
        logic         write;
        logic [31:0]  addr;
        logic [255:0] wr_data;
        logic [255:0] exp_rd;
    } vec_t;

    logic clk = 1'b0;
    logic reset4;
    logic reset1;

    int num_compared   = 0;
    int num_mismatched = 0;
    logic [255:0] last_rd;

    memory_interface #(.ADDR_SIZE(32), .CACHE_LINE_SIZE(256)) bus4 ();
    memory_interface #(.ADDR_SIZE(32), .CACHE_LINE_SIZE(256)) bus1 ();

    line_memory_responder #(
        .ADDR_SIZE(32), .CACHE_LINE_SIZE(256), .SIZE_LINES(1024), .LATENCY(LAT4)
    ) dut4 (
        .clk_i      (clk),
        .reset_i    (reset4),
        .memory_bus (bus4)
    );

    line_memory_responder #(
        .ADDR_SIZE(32), .CACHE_LINE_SIZE(256), .SIZE_LINES(1024), .LATENCY(LAT1)
    ) dut1 (
        .clk_i      (clk),
        .reset_i    (reset1),
        .memory_bus (bus1)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exceeded, got timeout required completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [255:0] actual,
                                input logic [255:0] expected);
        num_compared++;
        if (actual !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got %h required %h", name, actual, expected);
        end
    endtask

    // One full handshake on the LATENCY=4 instance, holding the request until ready.
    task automatic apply_stimulus(input vec_t v, input string tag);
        int k;
        @(negedge clk);
        bus4.write   = v.write;
        bus4.addr    = v.addr;
        bus4.wr_data = v.wr_data;
        bus4.valid   = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus4.ready && k < 20);
        check_output({tag, " latency"}, 256'(k), 256'(LAT4));
        if (v.write) begin
            check_output({tag, " rd_hold"}, bus4.rd_data, last_rd);
        end else begin
            check_output({tag, " rd_data"}, bus4.rd_data, v.exp_rd);
            last_rd = v.exp_rd;
        end
        bus4.valid = 1'b0;
        @(negedge clk);
        check_output({tag, " pulse"}, 256'(bus4.ready), 256'(0));
    endtask

    initial begin
        vec_t vectors [9];
        logic [31:0]  b2b_addr [3];
        logic [31:0]  b2b_garb [3];
        logic [255:0] b2b_exp  [3];
        int  txn;
        logic exp_r;
        logic saw_ready;

        vectors[0] = '{1'b1, 32'h0000_0040, D1,   '0};
        vectors[1] = '{1'b0, 32'h0000_0040, '0,   D1};
        vectors[2] = '{1'b0, 32'h0000_005F, '0,   D1};
        vectors[3] = '{1'b1, 32'h0000_8040, D2,   '0};
        vectors[4] = '{1'b0, 32'h0000_0040, '0,   D2};
        vectors[5] = '{1'b1, 32'h0000_0060, D3,   '0};
        vectors[6] = '{1'b1, 32'h0000_0020, D4,   '0};
        vectors[7] = '{1'b0, 32'h0000_0060, '0,   D3};
        vectors[8] = '{1'b0, 32'h0000_8020, '0,   D4};

        reset4       = 1'b1;
        reset1       = 1'b1;
        bus4.valid   = 1'b0;
        bus4.write   = 1'b0;
        bus4.addr    = '0;
        bus4.wr_data = '0;
        // The LATENCY=1 master already presents a write while still in reset.
        bus1.valid   = 1'b1;
        bus1.write   = 1'b1;
        bus1.addr    = 32'h0000_0020;
        bus1.wr_data = D4;

        repeat (3) @(negedge clk);
        check_output("reset ready4", 256'(bus4.ready), 256'(0));
        check_output("reset rd_data4", bus4.rd_data, '0);
        check_output("reset ready1 valid held", 256'(bus1.ready), 256'(0));
        reset4  = 1'b0;
        last_rd = '0;

        $display("[TB] table vectors on LATENCY=4 instance");
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(vectors[i], $sformatf("vec%0d", i));
        end

        $display("[TB] back-to-back reads with address churn during BUSY");
        b2b_addr = '{32'h40, 32'h60, 32'h20};
        b2b_garb = '{32'h60, 32'h20, 32'h40};
        b2b_exp  = '{D2, D3, D4};
        @(negedge clk);
        bus4.write = 1'b0;
        bus4.addr  = b2b_addr[0];
        bus4.valid = 1'b1;
        txn = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp_r = (k == 4) || (k == 9) || (k == 14);
            check_output($sformatf("b2b ready k%0d", k), 256'(bus4.ready), 256'(exp_r));
            if (exp_r) begin
                check_output($sformatf("b2b rd_data txn%0d", txn), bus4.rd_data, b2b_exp[txn]);
                txn++;
                if (txn < 3) bus4.addr = b2b_addr[txn];
                else         bus4.valid = 1'b0;
            end else if ((k == 2) || (k == 7) || (k == 12)) begin
                bus4.addr = b2b_garb[txn];
            end
        end
        last_rd = D4;

        $display("[TB] reset during BUSY discards the write");
        @(negedge clk);
        bus4.write   = 1'b1;
        bus4.addr    = 32'h0000_0040;
        bus4.wr_data = DA5;
        bus4.valid   = 1'b1;
        @(negedge clk);
        reset4 = 1'b1;
        #1;
        check_output("midreset ready", 256'(bus4.ready), 256'(0));
        check_output("midreset rd_data", bus4.rd_data, '0);
        bus4.valid = 1'b0;
        @(negedge clk);
        reset4    = 1'b0;
        saw_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus4.ready) saw_ready = 1'b1;
        end
        check_output("midreset no ready", 256'(saw_ready), 256'(0));
        last_rd = '0;
        apply_stimulus('{1'b0, 32'h0000_0040, '0, D2}, "postreset read");

        $display("[TB] LATENCY=1 instance, reset released with valid high");
        @(negedge clk);
        reset1 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            exp_r = k[0];
            check_output($sformatf("lat1 ready k%0d", k), 256'(bus1.ready), 256'(exp_r));
            if (k == 1) begin
                check_output("lat1 write rd_hold", bus1.rd_data, '0);
                bus1.write = 1'b0;
            end else if (exp_r) begin
                check_output($sformatf("lat1 rd_data k%0d", k), bus1.rd_data, D4);
            end
        end
        bus1.valid = 1'b0;
        @(negedge clk);
        check_output("lat1 idle", 256'(bus1.ready), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
